// File: rtl/ram_scan_ctrl.sv
// RAM scan/fill controller.
// FILL writes a captured value to every RAM address. SCAN reads every
// address, drops zero words (counting them), and streams the nonzero words
// with their addresses through a 4-entry FIFO.
// Read timing: an address is issued into ram_rd_add, the RAM registers its
// data on the next edge, and the controller consumes that data on the edge
// after that. Up to two reads can therefore be in flight at once.
module ram_scan_ctrl #(
  parameter int ram_width  = 8,
  parameter int data_width = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_scan,
  input  logic                  start_fill,
  input  logic [data_width-1:0] fill_data,
  output logic                  busy,
  output logic                  done,
  output logic [ram_width-1:0]  ram_rd_add,
  input  logic [data_width-1:0] ram_rd_data,
  output logic [ram_width-1:0]  ram_wr_add,
  output logic [data_width-1:0] ram_wr_data,
  output logic                  ram_wr_req,
  output logic                  pix_valid,
  output logic [data_width-1:0] pix_data,
  output logic [ram_width-1:0]  pix_add,
  input  logic                  pix_ready,
  output logic [ram_width:0]    skip_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FILL} state_t;

  localparam logic [ram_width-1:0] ADD_LAST = '1;

  state_t                state_q, state_d;
  logic [ram_width-1:0]  rd_add_q;
  logic                  rd_vld1_q, rd_vld2_q;   // read in address reg / in RAM output reg
  logic [ram_width-1:0]  rd_tag2_q;              // address belonging to ram_rd_data
  logic [ram_width-1:0]  wr_add_q;
  logic [data_width-1:0] wr_data_q;
  logic                  wr_req_q;
  logic                  done_q;
  logic [ram_width:0]    skip_q;
  logic [data_width-1:0] fd_q [4];
  logic [ram_width-1:0]  fa_q [4];
  logic [1:0]            wp_q, rp_q;
  logic [2:0]            cnt_q;

  logic                  scan_acc, fill_acc, can_issue, issue, push, pop;
  logic [2:0]            inflight;
  logic [ram_width-1:0]  nxt_rd_add, issue_add;

  assign inflight   = 3'(rd_vld1_q) + 3'(rd_vld2_q);
  // Reserve a FIFO slot for every read in flight so returned data always fits.
  assign can_issue  = (cnt_q + inflight) < 3'd4;
  assign nxt_rd_add = rd_add_q + 1'b1;
  assign push       = rd_vld2_q && (ram_rd_data != '0);
  assign pop        = (cnt_q != 3'd0) && pix_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; fill has priority over scan when both are requested
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_fill) state_d = FILL;
             else if (start_scan) state_d = SCAN;
      SCAN:  if (can_issue && nxt_rd_add == ADD_LAST) state_d = DRAIN;
      DRAIN: if (!rd_vld1_q && !rd_vld2_q && cnt_q == 3'd0) state_d = IDLE;
      FILL:  if (wr_add_q == ADD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode; address 0 is issued on the accepting edge itself
  always_comb begin
    busy      = (state_q != IDLE);
    fill_acc  = (state_q == IDLE) && start_fill;
    scan_acc  = (state_q == IDLE) && start_scan && !start_fill;
    issue     = scan_acc || ((state_q == SCAN) && can_issue);
    issue_add = scan_acc ? '0 : nxt_rd_add;
  end

  // Read pipeline: address register then RAM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_add_q  <= '0;
      rd_vld1_q <= 1'b0;
      rd_vld2_q <= 1'b0;
      rd_tag2_q <= '0;
    end else begin
      if (issue) rd_add_q <= issue_add;
      rd_vld1_q <= issue;
      rd_vld2_q <= rd_vld1_q;
      rd_tag2_q <= rd_add_q;
    end
  end

  // Fill write port: one write per cycle over the whole address range
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_add_q  <= '0;
      wr_data_q <= '0;
      wr_req_q  <= 1'b0;
    end else if (fill_acc) begin
      wr_add_q  <= '0;
      wr_data_q <= fill_data;
      wr_req_q  <= 1'b1;
    end else if (state_q == FILL) begin
      if (wr_add_q == ADD_LAST) wr_req_q <= 1'b0;
      else                      wr_add_q <= wr_add_q + 1'b1;
    end
  end

  // Pixel FIFO; occupancy handles simultaneous push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        fd_q[i] <= '0;
        fa_q[i] <= '0;
      end
      wp_q  <= 2'd0;
      rp_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (push) begin
        fd_q[wp_q] <= ram_rd_data;
        fa_q[wp_q] <= rd_tag2_q;
        wp_q       <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + 3'(push) - 3'(pop);
    end
  end

  // Zero-entry counter and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (scan_acc)                            skip_q <= '0;
      else if (rd_vld2_q && ram_rd_data == '0) skip_q <= skip_q + (ram_width+1)'(1);
      done_q <= ((state_q == FILL) || (state_q == DRAIN)) && (state_d == IDLE);
    end
  end

  assign done        = done_q;
  assign ram_rd_add  = rd_add_q;
  assign ram_wr_add  = wr_add_q;
  assign ram_wr_data = wr_data_q;
  assign ram_wr_req  = wr_req_q;
  assign pix_valid   = (cnt_q != 3'd0);
  assign pix_data    = fd_q[rp_q];
  assign pix_add     = fa_q[rp_q];
  assign skip_count  = skip_q;

endmodule
